// File: rtl/multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// multi_pulse_generator
//
// CH independent pulse-train channels. Each channel produces a registered,
// glitch-free output with programmable period (ticks) and high time
// (high_ticks). Three operating modes are available per channel: continuous,
// one-shot, or an N-period burst.
//
// Control semantics: start, stop and ena are plain levels sampled on posedge
// clk; there is no valid/ready back-pressure. A start is accepted only when
// the channel is IDLE, ena=1, stop=0 and the presented configuration is
// usable. Otherwise it is dropped, and the requester may simply hold or
// re-issue it. stop is an unconditional abort and has priority over
// everything else.
//
// Ports:
//   clk        : system clock; all flops are on posedge
//   rst        : asynchronous reset, active low
//   ena        [CH]      : per-channel count enable (0 = pause)
//   start      [CH]      : per-channel start request
//   stop       [CH]      : per-channel synchronous abort
//   mode       [2*CH]    : channel i at [2i+:2]
//                          00 continuous, 01 one-shot, 10 burst, 11 reserved
//   ticks      [N*CH]    : channel i at [Ni+:N]; period in clocks
//   high_ticks [N*CH]    : channel i at [Ni+:N]; high clocks per period
//   burst      [BW*CH]   : channel i at [BWi+:BW]; periods per burst
//   out        [CH]      : registered pulse outputs
//   busy       [CH]      : channel is in RUN (this is the FSM state bit)
//   done       [CH]      : one-cycle completion strobe
// -----------------------------------------------------------------------------
module multi_pulse_generator #(
    parameter int N  = 16,
    parameter int CH = 4,
    parameter int BW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     ena,
    input  logic [CH-1:0]     start,
    input  logic [CH-1:0]     stop,
    input  logic [2*CH-1:0]   mode,
    input  logic [N*CH-1:0]   ticks,
    input  logic [N*CH-1:0]   high_ticks,
    input  logic [BW*CH-1:0]  burst,
    output logic [CH-1:0]     out,
    output logic [CH-1:0]     busy,
    output logic [CH-1:0]     done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_CONT  = 2'b00;
    localparam logic [1:0] MODE_ONE   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t         state_q, state_d;
        logic [N-1:0]   cnt_q, cnt_d;
        logic [N-1:0]   tk_q, tk_d;
        logic [N-1:0]   hi_q, hi_d;
        logic [1:0]     md_q, md_d;
        logic [BW-1:0]  bc_q, bc_d;
        logic [BW-1:0]  pc_q, pc_d;
        logic           out_q, out_d;
        logic           done_q, done_d;

        logic [N-1:0]   in_tk;
        logic [N-1:0]   in_hi;
        logic [1:0]     in_md;
        logic [BW-1:0]  in_bc;
        logic           cfg_ok;
        logic           wrap;
        logic [N-1:0]   cnt_inc;
        logic [BW-1:0]  pc_inc;

        assign in_tk = ticks[N*i +: N];
        assign in_hi = high_ticks[N*i +: N];
        assign in_md = mode[2*i +: 2];
        assign in_bc = burst[BW*i +: BW];

        // A configuration is usable when it describes a non-empty period in a
        // defined mode; a burst additionally needs at least one period.
        assign cfg_ok = (in_tk != '0) && (in_md != MODE_RSVD) &&
                        ((in_md != MODE_BURST) || (in_bc != '0));

        // tk_q is never zero while in RUN, so tk_q-1 cannot underflow there.
        assign wrap    = (cnt_q == tk_q - N'(1));
        assign cnt_inc = cnt_q + N'(1);
        assign pc_inc  = pc_q + BW'(1);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                tk_q    <= '0;
                hi_q    <= '0;
                md_q    <= '0;
                bc_q    <= '0;
                pc_q    <= '0;
                out_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tk_q    <= tk_d;
                hi_q    <= hi_d;
                md_q    <= md_d;
                bc_q    <= bc_d;
                pc_q    <= pc_d;
                out_q   <= out_d;
                done_q  <= done_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tk_d    = tk_q;
            hi_d    = hi_q;
            md_d    = md_q;
            bc_d    = bc_q;
            pc_d    = pc_q;
            out_d   = out_q;
            done_d  = 1'b0;

            if (stop[i]) begin
                state_d = IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
                pc_d    = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start[i] && ena[i] && cfg_ok) begin
                            state_d = RUN;
                            tk_d    = in_tk;
                            hi_d    = in_hi;
                            md_d    = in_md;
                            bc_d    = in_bc;
                            cnt_d   = '0;
                            pc_d    = '0;
                            out_d   = (in_hi != '0);
                        end
                    end
                    RUN: begin
                        // ena=0 leaves every default (hold) in place.
                        if (ena[i]) begin
                            if (!wrap) begin
                                cnt_d = cnt_inc;
                                out_d = (cnt_inc < hi_q);
                            end else begin
                                case (md_q)
                                    MODE_ONE: begin
                                        state_d = IDLE;
                                        out_d   = 1'b0;
                                        cnt_d   = '0;
                                        done_d  = 1'b1;
                                    end
                                    MODE_BURST: begin
                                        pc_d = pc_inc;
                                        if (pc_inc == bc_q) begin
                                            state_d = IDLE;
                                            out_d   = 1'b0;
                                            cnt_d   = '0;
                                            done_d  = 1'b1;
                                        end else begin
                                            cnt_d = '0;
                                            out_d = (hi_q != '0);
                                        end
                                    end
                                    default: begin
                                        // Continuous: new parameters only take
                                        // effect here, at a period boundary.
                                        // An unusable input set keeps the
                                        // current configuration running.
                                        cnt_d = '0;
                                        pc_d  = '0;
                                        if (cfg_ok) begin
                                            tk_d  = in_tk;
                                            hi_d  = in_hi;
                                            md_d  = in_md;
                                            bc_d  = in_bc;
                                            out_d = (in_hi != '0);
                                        end else begin
                                            out_d = (hi_q != '0);
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        assign out[i]  = out_q;
        assign busy[i] = (state_q == RUN);
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_multi_pulse_generator
//
// Directed bench for multi_pulse_generator. Each scenario task drives its own
// stimulus and compares {out,busy,done} against hand-computed tables. The
// outputs are sampled 1 ns after each rising edge. Sample index k is taken
// after edge E0+k, where E0 is the edge that sampled start.
// -----------------------------------------------------------------------------
module tb_multi_pulse_generator;
    localparam int N  = 16;
    localparam int CH = 4;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     ena;
    logic [CH-1:0]     start;
    logic [CH-1:0]     stop;
    logic [2*CH-1:0]   mode;
    logic [N*CH-1:0]   ticks;
    logic [N*CH-1:0]   high_ticks;
    logic [BW*CH-1:0]  burst;
    logic [CH-1:0]     out;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     done;

    int checks = 0;
    int errors = 0;

    multi_pulse_generator #(.N(N), .CH(CH), .BW(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .ticks      (ticks),
        .high_ticks (high_ticks),
        .burst      (burst),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int c, input logic [1:0] m, input logic [N-1:0] t,
                       input logic [N-1:0] h, input logic [BW-1:0] b);
        mode[2*c +: 2]        = m;
        ticks[N*c +: N]       = t;
        high_ticks[N*c +: N]  = h;
        burst[BW*c +: BW]     = b;
    endtask

    task automatic fire(input logic [CH-1:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic halt_all();
        stop = '1;
        step();
        stop = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < CH; c++) cfg(c, 2'b01, 16'd4, 16'd2, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = (k % 2 == 0) ? '1 : '0;
            step();
            checks++;
            if ({out, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got out=%b busy=%b done=%b exp all 0",
                         k, out, busy, done);
            end
        end
        start = '0;
        rst   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_release[%0d] got out=%b busy=%b done=%b exp all 0",
                         k, out, busy, done);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [2:0] e [0:6] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
        cfg(0, 2'b01, 16'd4, 16'd2, 8'd0);
        fire(4'b0001);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[0], busy[0], done[0]} !== e[k]) begin
                errors++;
                $display("FAIL oneshot[%0d] got {out,busy,done}=%b exp=%b",
                         k, {out[0], busy[0], done[0]}, e[k]);
            end
            // start held during RUN must not retrigger
            if (k == 0) start[0] = 1'b1;
            if (k == 3) start[0] = 1'b0;
        end
    endtask

    task automatic test_continuous();
        logic [11:0] e_out = 12'b1001_0010_0111; // bit k = expected out at sample k
        cfg(1, 2'b00, 16'd5, 16'd3, 8'd0);
        fire(4'b0010);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[1], busy[1], done[1]} !== {e_out[k], 2'b10}) begin
                errors++;
                $display("FAIL continuous[%0d] got {out,busy,done}=%b exp=%b",
                         k, {out[1], busy[1], done[1]}, {e_out[k], 2'b10});
            end
            // mid-period change: applies only after the 5-cycle period ends
            if (k == 2) cfg(1, 2'b00, 16'd3, 16'd1, 8'd0);
        end
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        checks++;
        if ({out[1], busy[1], done[1]} !== 3'b000) begin
            errors++;
            $display("FAIL continuous_stop got {out,busy,done}=%b exp=000",
                     {out[1], busy[1], done[1]});
        end
    endtask

    task automatic test_burst();
        logic [2:0] e [0:13] = '{3'b110, 3'b010, 3'b010, 3'b110, 3'b010, 3'b010,
                                 3'b110, 3'b010, 3'b010, 3'b110, 3'b010, 3'b010,
                                 3'b001, 3'b000};
        cfg(2, 2'b10, 16'd3, 16'd1, 8'd4);
        fire(4'b0100);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[2], busy[2], done[2]} !== e[k]) begin
                errors++;
                $display("FAIL burst[%0d] got {out,busy,done}=%b exp=%b",
                         k, {out[2], busy[2], done[2]}, e[k]);
            end
        end
        cfg(2, 2'b10, 16'd3, 16'd1, 8'd0);
        fire(4'b0100);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[2], busy[2], done[2]} !== 3'b000) begin
                errors++;
                $display("FAIL burst_zero[%0d] got {out,busy,done}=%b exp=000",
                         k, {out[2], busy[2], done[2]});
            end
        end
    endtask

    task automatic test_pause();
        logic [2:0] e [0:10] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
                                 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        cfg(3, 2'b01, 16'd6, 16'd3, 8'd0);
        fire(4'b1000);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[3], busy[3], done[3]} !== e[k]) begin
                errors++;
                $display("FAIL pause[%0d] got {out,busy,done}=%b exp=%b",
                         k, {out[3], busy[3], done[3]}, e[k]);
            end
            if (k == 1) ena[3] = 1'b0;  // edges 2,3,4 paused
            if (k == 4) ena[3] = 1'b1;
        end
    endtask

    task automatic test_stop_at_wrap();
        logic [2:0] e [0:5] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b000, 3'b000};
        cfg(0, 2'b01, 16'd4, 16'd2, 8'd0);
        fire(4'b0001);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            checks++;
            if ({out[0], busy[0], done[0]} !== e[k]) begin
                errors++;
                $display("FAIL stop_wrap[%0d] got {out,busy,done}=%b exp=%b",
                         k, {out[0], busy[0], done[0]}, e[k]);
            end
            if (k == 3) stop[0] = 1'b1;  // coincides with the final wrap edge
            if (k == 4) stop[0] = 1'b0;
        end
    endtask

    task automatic test_ignored_starts();
        // ticks=0, reserved mode, and ena=0 must all drop the start
        for (int v = 0; v < 3; v++) begin
            if (v == 0) cfg(0, 2'b00, 16'd0, 16'd1, 8'd0);
            if (v == 1) cfg(0, 2'b11, 16'd4, 16'd2, 8'd1);
            if (v == 2) begin
                cfg(0, 2'b00, 16'd4, 16'd2, 8'd0);
                ena[0] = 1'b0;
            end
            fire(4'b0001);
            step();
            checks++;
            if ({out[0], busy[0], done[0]} !== 3'b000) begin
                errors++;
                $display("FAIL ignored_start[%0d] got {out,busy,done}=%b exp=000",
                         v, {out[0], busy[0], done[0]});
            end
            ena[0] = 1'b1;
        end
    endtask

    task automatic test_boundaries();
        // v0: ticks=1 high=1 -> const high; v1: high=10>ticks=4 -> const high;
        // v2: high=0 -> const low while busy
        logic [2:0] e [0:2] = '{3'b110, 3'b110, 3'b010};
        for (int v = 0; v < 3; v++) begin
            if (v == 0) cfg(1, 2'b00, 16'd1, 16'd1, 8'd0);
            if (v == 1) cfg(1, 2'b00, 16'd4, 16'd10, 8'd0);
            if (v == 2) cfg(1, 2'b00, 16'd4, 16'd0, 8'd0);
            fire(4'b0010);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) step();
                checks++;
                if ({out[1], busy[1], done[1]} !== e[v]) begin
                    errors++;
                    $display("FAIL boundary%0d[%0d] got {out,busy,done}=%b exp=%b",
                             v, k, {out[1], busy[1], done[1]}, e[v]);
                end
            end
            halt_all();
        end
    endtask

    task automatic test_concurrent();
        logic [3:0] e_out  [0:9] = '{4'b1111, 4'b0011, 4'b1010, 4'b0100, 4'b1000,
                                     4'b0010, 4'b1010, 4'b0010, 4'b1000, 4'b0000};
        logic [3:0] e_busy [0:9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110,
                                     4'b1110, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        logic [3:0] e_done [0:9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                     4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        cfg(0, 2'b01, 16'd4, 16'd2, 8'd0);
        cfg(1, 2'b00, 16'd5, 16'd3, 8'd0);
        cfg(2, 2'b10, 16'd3, 16'd1, 8'd2);
        cfg(3, 2'b00, 16'd2, 16'd1, 8'd0);
        fire(4'b1111);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            checks++;
            if ({out, busy, done} !== {e_out[k], e_busy[k], e_done[k]}) begin
                errors++;
                $display("FAIL concurrent[%0d] got out=%b busy=%b done=%b exp out=%b busy=%b done=%b",
                         k, out, busy, done, e_out[k], e_busy[k], e_done[k]);
            end
        end
        halt_all();
    endtask

    task automatic test_async_reset();
        cfg(0, 2'b00, 16'd5, 16'd3, 8'd0);
        fire(4'b0001);
        step();
        checks++;
        if ({out[0], busy[0]} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre got {out,busy}=%b exp=11", {out[0], busy[0]});
        end
        #2 rst = 1'b0;   // between edges
        #1;
        checks++;
        if ({out, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset got out=%b busy=%b done=%b exp all 0",
                     out, busy, done);
        end
        rst      = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if ({out[0], busy[0], done[0]} !== 3'b110) begin
            errors++;
            $display("FAIL first_start_after_reset got {out,busy,done}=%b exp=110",
                     {out[0], busy[0], done[0]});
        end
        halt_all();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst        = 1'b0;
        ena        = '1;
        start      = '0;
        stop       = '0;
        mode       = '0;
        ticks      = '0;
        high_ticks = '0;
        burst      = '0;

        test_reset();
        test_oneshot();
        test_continuous();
        test_burst();
        test_pause();
        test_stop_at_wrap();
        test_ignored_starts();
        test_boundaries();
        test_concurrent();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
- CH-channel generalisation of the single-period pulse generator.
- Each channel produces a registered, glitch-free pulse train with programmable period and high time.
- Modes per channel: continuous, one-shot, or N-period burst; start/stop control, busy/done status.
- Sits between control logic (button/FSM/register block) and timed consumers such as display refresh, stepper and LED blink.

Parameters:
- N, 16, width of period and high-time fields.
- CH, 4, number of independent channels.
- BW, 8, width of burst-count field.

Ports:
- clk  input  1  system clock, all flops on posedge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  CH  per-channel count enable; 0 pauses channel.
- start  input  CH  per-channel start request, sampled on posedge.
- stop  input  CH  per-channel synchronous abort.
- mode  input  2*CH  channel i at [2i+:2]: 00 continuous, 01 one-shot, 10 burst, 11 reserved.
- ticks  input  N*CH  channel i at [Ni+:N]; period in clocks.
- high_ticks  input  N*CH  channel i at [Ni+:N]; clocks out is high per period.
- burst  input  BW*CH  channel i at [BWi+:BW]; periods per burst.
- out  output  CH  pulse outputs, registered.
- busy  output  CH  channel in RUN state.
- done  output  CH  one-cycle completion strobe.

Behaviour:
- Channels are fully independent: identical logic replicated CH times, no shared state.
- Reset (rst=0, async): state IDLE, cnt=0, period count=0, latched config=0, out=0, busy=0, done=0.
- All outputs are flops. No clock gating and no clk term in any output.
- States: IDLE, RUN. busy = (state==RUN). Mode 11 behaves as permanently IDLE (start ignored).
- IDLE->RUN:
  - Occurs at an edge with start=1, ena=1, stop=0, ticks!=0, mode!=11.
  - Burst mode additionally requires burst!=0.
  - The start edge latches ticks/high_ticks/mode/burst, sets cnt=0 and period count=0.
  - Same edge: out <= (high_ticks!=0). Output latency from start sample is 1 cycle.
- Start is ignored in all other cases, including while in RUN (no retrigger).
- RUN, ena=1:
  - cnt increments each edge; cnt wraps at latched ticks-1.
  - out <= (next cnt < latched high_ticks).
  - high_ticks >= ticks gives out constantly high; high_ticks=0 gives out constantly low.
- RUN, ena=0: cnt, period count, state and out all hold (pause). done is never raised while paused.
- Period wrap (cnt==ticks-1, ena=1):
  - Continuous: cnt<=0 and config is re-latched from the inputs. Parameter changes therefore take effect only at period boundaries.
  - One-shot: state<=IDLE, out<=0, done<=1.
  - Burst: period count increments. When it reaches the latched burst value: state<=IDLE, out<=0, done<=1. Otherwise cnt<=0.
- done is high exactly one cycle per completion and is never raised by stop or continuous mode.
- stop=1 at an edge: state<=IDLE, out<=0, cnt<=0, done<=0 next cycle. stop wins over start and over a simultaneous wrap.
- ticks=1: period of one clock; in continuous mode with high_ticks>=1, out stays high.
- Widths:
  - cnt is N bits; comparisons are unsigned N-bit.
  - Period count is BW bits.
  - No overflow is possible because cnt never exceeds ticks-1.
- Reset asserted mid-operation returns the channel to reset values immediately. The first start is accepted on the first edge after rst deasserts.

Test Plan:
- Reset: rst=0 with start=1111 toggling -> out=busy=done=0 throughout. After release, no output until start.
- One-shot: ticks=4, high_ticks=2, start on edge E0:
  - out=1 for 2 cycles, then 0 for 2.
  - busy=1 for 4 cycles.
  - done=1 in the 5th cycle only.
- Continuous:
  - ticks=5, high_ticks=3 -> repeating 3 high / 2 low.
  - Change ticks to 3 mid-period -> the new period starts only after the current 5-cycle period completes.
- Burst: ticks=3, high_ticks=1, burst=4 -> exactly 4 high pulses spaced 3 cycles, then done pulse and busy=0.
  - Repeat with burst=0 -> start ignored.
- Pause and stop:
  - One-shot ticks=6 with ena=0 for 3 cycles mid-period -> out holds, total busy = 9 cycles.
  - stop coincident with final wrap -> no done.
- Boundaries and independence:
  - ticks=0 -> start ignored.
  - ticks=1, high_ticks=1 continuous -> out constantly 1.
  - high_ticks=10 > ticks=4 -> out high full period.
  - All four channels run with different configs concurrently -> no cross-channel interaction.
